// File: rtl/row_assembler.sv
`default_nettype none
// ============================================================================
// row_assembler : serial value stream -> ping-pong row buffer feeding cnn_layer
// Revision      : 1.0
// ============================================================================
module row_assembler #(
  parameter int VALUE_BITS  = 8,
  parameter int WIDTH       = 28,
  parameter int IN_CHANNELS = 1,
  parameter int HEIGHT      = 28
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [VALUE_BITS-1:0] value_i,
  input  logic                  value_valid_i,
  output logic                  value_ready_o,
  output logic [VALUE_BITS-1:0] out_row_o [WIDTH][IN_CHANNELS],
  output logic                  out_row_valid_o,
  input  logic                  out_row_accept_i,
  output logic                  out_row_last_o
);

  localparam int c_CH_W  = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int c_COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int c_ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [c_CH_W-1:0]  c_CH_MAX  = c_CH_W'(IN_CHANNELS - 1);
  localparam logic [c_COL_W-1:0] c_COL_MAX = c_COL_W'(WIDTH - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_MAX = c_ROW_W'(HEIGHT - 1);

  logic [VALUE_BITS-1:0] r_buf [2][WIDTH][IN_CHANNELS];
  logic [c_CH_W-1:0]     r_ch;
  logic [c_COL_W-1:0]    r_col;
  logic [c_ROW_W-1:0]    r_row;
  logic                  r_wr_sel;
  logic                  r_rd_sel;
  logic [1:0]            r_full_count;
  logic [1:0]            r_last;

  logic w_take;
  logic w_done;
  logic w_xfer;

  // Ready depends only on occupancy, so upstream sees no combinational loop.
  assign value_ready_o   = (r_full_count != 2'd2);
  assign out_row_valid_o = (r_full_count != 2'd0);
  assign out_row_last_o  = out_row_valid_o && r_last[r_rd_sel];

  assign w_take = value_valid_i && value_ready_o;
  assign w_done = w_take && (r_ch == c_CH_MAX) && (r_col == c_COL_MAX);
  assign w_xfer = out_row_valid_o && out_row_accept_i;

  always_comb begin
    for (int c = 0; c < WIDTH; c++) begin
      for (int h = 0; h < IN_CHANNELS; h++) begin
        out_row_o[c][h] = r_buf[r_rd_sel][c][h];
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int c = 0; c < WIDTH; c++) begin
        for (int h = 0; h < IN_CHANNELS; h++) begin
          r_buf[0][c][h] <= '0;
          r_buf[1][c][h] <= '0;
        end
      end
      r_ch         <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_wr_sel     <= 1'b0;
      r_rd_sel     <= 1'b0;
      r_full_count <= 2'd0;
      r_last       <= 2'b00;
    end else begin
      if (w_take) begin
        r_buf[r_wr_sel][r_col][r_ch] <= value_i;
        if (r_ch == c_CH_MAX) begin
          r_ch <= '0;
          if (r_col == c_COL_MAX) begin
            r_col <= '0;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end else begin
          r_ch <= r_ch + 1'b1;
        end
      end

      if (w_done) begin
        r_last[r_wr_sel] <= (r_row == c_ROW_MAX);
        r_wr_sel         <= ~r_wr_sel;
        r_row            <= (r_row == c_ROW_MAX) ? '0 : r_row + 1'b1;
      end

      if (w_xfer) begin
        r_rd_sel <= ~r_rd_sel;
      end

      // Completion and hand-off in the same edge leave occupancy unchanged.
      case ({w_done, w_xfer})
        2'b10:   r_full_count <= r_full_count + 2'd1;
        2'b01:   r_full_count <= r_full_count - 2'd1;
        default: r_full_count <= r_full_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_row_assembler.sv
`default_nettype none
// tb_row_assembler : queue-model check of a 4x2x3 row_assembler plus a
// default-size (28x1x28) image run.
module tb_row_assembler;

  logic clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  logic reset_i;

  logic [7:0] s_val;
  logic       s_valid, s_acc, s_ready, s_ovalid, s_last;
  logic [7:0] s_row [4][2];

  logic [7:0] b_val;
  logic       b_valid, b_acc, b_ready, b_ovalid, b_last;
  logic [7:0] b_row [28][1];

  row_assembler #(.VALUE_BITS(8), .WIDTH(4), .IN_CHANNELS(2), .HEIGHT(3)) u_small (
    .clock_i(clock_i), .reset_i(reset_i), .value_i(s_val), .value_valid_i(s_valid),
    .value_ready_o(s_ready), .out_row_o(s_row), .out_row_valid_o(s_ovalid),
    .out_row_accept_i(s_acc), .out_row_last_o(s_last));

  row_assembler u_big (
    .clock_i(clock_i), .reset_i(reset_i), .value_i(b_val), .value_valid_i(b_valid),
    .value_ready_o(b_ready), .out_row_o(b_row), .out_row_valid_o(b_ovalid),
    .out_row_accept_i(b_acc), .out_row_last_o(b_last));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Small DUT row flattened: value k (k = 2*col + ch) in byte k.
  logic [63:0] s_flat;
  always_comb begin
    s_flat = '0;
    for (int c = 0; c < 4; c++)
      for (int h = 0; h < 2; h++)
        s_flat[8*(2*c+h) +: 8] = s_row[c][h];
  end

  // Model: queue of completed rows awaiting hand-off, plus the row being filled.
  logic [63:0] m_data [$];
  bit          m_last [$];
  logic [63:0] m_part;
  int          m_cnt;
  int          m_row;
  bit          cmp_en = 1'b0;

  task automatic cyc(input bit v, input logic [7:0] d, input bit a, output bit taken);
    bit xfer;
    s_valid = v; s_val = d; s_acc = a;
    xfer  = (m_data.size() != 0) && a;
    taken = v && (m_data.size() < 2) && !reset_i;
    @(posedge clock_i);
    if (reset_i) begin
      m_data.delete(); m_last.delete(); m_cnt = 0; m_row = 0;
    end else begin
      if (xfer) begin
        void'(m_data.pop_front());
        void'(m_last.pop_front());
      end
      if (taken) begin
        m_part[8*m_cnt +: 8] = d;
        m_cnt++;
        if (m_cnt == 8) begin
          m_data.push_back(m_part);
          m_last.push_back(m_row == 2);
          m_row = (m_row + 1) % 3;
          m_cnt = 0;
        end
      end
    end
    @(negedge clock_i);
  endtask

  task automatic send(input logic [7:0] d, input bit a);
    bit t;
    t = 1'b0;
    for (int i = 0; i < 40 && !t; i++) cyc(1'b1, d, a, t);
    if (!t) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: value %0d never taken", d);
    end
  endtask

  always @(negedge clock_i) begin
    if (cmp_en) begin
      chk("ready", s_ready, m_data.size() < 2);
      chk("valid", s_ovalid, m_data.size() != 0);
      if (m_data.size() != 0) begin
        chk("row", s_flat, m_data[0]);
        chk("last", s_last, m_last[0]);
      end else begin
        chk("last_idle", s_last, 0);
      end
    end
  end

  // Default-size monitor: pixel stream k%256 gives row r, column c the value (28r+c)%256.
  int b_rows = 0;
  int b_lasts = 0;
  int b_bad;
  always @(negedge clock_i) begin
    if (cmp_en && b_ovalid) begin
      b_bad = 0;
      for (int c = 0; c < 28; c++)
        if (b_row[c][0] !== 8'((b_rows * 28 + c) % 256)) b_bad++;
      chk("big_row_data", b_bad, 0);
      chk("big_last", b_last, b_rows == 27);
      if (b_last) b_lasts++;
      b_rows++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit t;
    bit rdy;
    int k;
    int n;
    reset_i = 1'b1;
    s_valid = 0; s_val = 0; s_acc = 0;
    b_valid = 0; b_val = 0; b_acc = 0;
    m_cnt = 0; m_row = 0; m_part = '0;
    cyc(0, 0, 0, t);
    cyc(0, 0, 0, t);
    reset_i = 1'b0;
    cmp_en  = 1'b1;
    chk("rst_ready", s_ready, 1);
    chk("rst_valid", s_ovalid, 0);
    chk("rst_last", s_last, 0);
    chk("rst_row", s_flat, 0);
    chk("rst_big_valid", b_ovalid, 0);

    // One row straight through with accept held high.
    for (int i = 0; i < 8; i++) send(8'(i), 1);
    chk("p1_valid", s_ovalid, 1);
    chk("p1_r3c1", s_row[3][1], 7);
    chk("p1_r1c0", s_row[1][0], 2);
    chk("p1_last", s_last, 0);
    cyc(0, 0, 1, t);
    chk("p1_drop", s_ovalid, 0);

    // Fill both buffers with no acceptance, then stall.
    for (int i = 0; i < 16; i++) send(8'(i), 0);
    chk("p2_ready_low", s_ready, 0);
    cyc(1, 16, 0, t);
    chk("p2_stall_ready", s_ready, 0);
    chk("p2_hold", s_row[3][1], 7);
    cyc(1, 16, 0, t);
    chk("p2_hold2", s_flat, 64'h0706050403020100);
    cyc(1, 16, 1, t);
    chk("p2_ready_back", s_ready, 1);
    chk("p2_row1", s_row[0][0], 8);
    chk("p2_row1_last", s_last, 1);
    for (int i = 16; i < 24; i++) send(8'(i), 1);
    chk("p2_row2", s_flat, 64'h1716151413121110);
    chk("p2_row2_last", s_last, 0);
    cyc(0, 0, 1, t);

    // Fresh image: only the third row is last, the fourth wraps.
    reset_i = 1'b1;
    cyc(0, 0, 0, t);
    reset_i = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) send(8'(100 + 8*r + i), 1);
      chk($sformatf("p3_last%0d", r), s_last, r == 2);
    end
    cyc(0, 0, 1, t);

    // Completion and hand-off on the same edge with one row pending.
    for (int i = 0; i < 8; i++) send(8'(40 + i), 0);
    for (int i = 0; i < 7; i++) send(8'(50 + i), 0);
    send(57, 1);
    chk("p4_valid", s_ovalid, 1);
    chk("p4_ready", s_ready, 1);
    chk("p4_rowB", s_row[0][0], 50);
    cyc(0, 0, 1, t);
    chk("p4_empty", s_ovalid, 0);

    // Move the row count off zero, then reset mid-row.
    for (int i = 0; i < 8; i++) send(8'(60 + i), 1);
    cyc(0, 0, 1, t);
    for (int i = 0; i < 5; i++) send(8'(70 + i), 1);
    reset_i = 1'b1;
    cyc(0, 0, 0, t);
    reset_i = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) send(8'(80 + 8*r + i), 1);
      if (r == 0) chk("p5_first", s_row[0][0], 80);
      chk($sformatf("p5_last%0d", r), s_last, r == 2);
    end
    cyc(0, 0, 1, t);

    // Default-size image, one value per cycle with accept held high.
    b_acc = 1'b1;
    k = 0;
    n = 0;
    while (k < 784 && n < 3000) begin
      b_valid = 1'b1;
      b_val   = 8'(k % 256);
      rdy     = b_ready;
      @(posedge clock_i);
      if (rdy) k++;
      n++;
      @(negedge clock_i);
    end
    b_valid = 1'b0;
    if (k < 784) begin
      n_cmp++; n_bad++;
      $display("FAIL big_stream_timeout: sent %0d of 784", k);
    end
    for (int i = 0; i < 4; i++) @(negedge clock_i);
    chk("big_rows", b_rows, 28);
    chk("big_lasts", b_lasts, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
